// File: rtl/fetch_pkg.sv
// Shared types and defaults for the 2-wide fetch controller.
package fetch_pkg;

    localparam logic [31:0] PC_STEP_DEFAULT     = 32'd8;
    localparam int          DONE_THRESH_DEFAULT = 10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst1;
        logic [31:0] inst2;
    } fetch_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-unit, decode and redirect signals of the fetch controller.
// master = the controller, slave = its environment.
interface fetch_ctrl_if;

    logic [31:0] fetch_pc;
    logic        fetch_req;
    logic [31:0] fetch_inst1;
    logic [31:0] fetch_inst2;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst1;
    logic [31:0] dec_inst2;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        done;

    modport master (
        output fetch_pc, fetch_req,
        input  fetch_inst1, fetch_inst2,
        output dec_valid, dec_pc, dec_inst1, dec_inst2,
        input  dec_ready,
        input  redirect_valid, redirect_pc,
        output done
    );

    modport slave (
        input  fetch_pc, fetch_req,
        output fetch_inst1, fetch_inst2,
        input  dec_valid, dec_pc, dec_inst1, dec_inst2,
        output dec_ready,
        output redirect_valid, redirect_pc,
        input  done
    );

endinterface

// File: rtl/fetch_pair_fifo.sv
// Small synchronous FIFO of fetch pairs; flush wins over push and pop.
module fetch_pair_fifo
    import fetch_pkg::*;
#(
    parameter  int BUF_DEPTH = 2,
    localparam int AW        = $clog2(BUF_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_pair_t   data_i,
    output logic [CW-1:0] count_o,
    output fetch_pair_t   head_o
);

    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_pair_t   mem_q [BUF_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_w;

    assign pop_w   = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_w);
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    // The issue rule in the controller must never let a push hit a full buffer.
    always_ff @(posedge clk) begin
        if (!rst && push_i && !flush_i)
            assert (count_q < DEPTH_C) else $error("fetch_pair_fifo: push into full buffer");
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer and buffering controller for the 2-wide fetch stage.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] PC_STEP     = PC_STEP_DEFAULT,
    parameter int          BUF_DEPTH   = 2,
    parameter int          DONE_THRESH = DONE_THRESH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_ctrl_if.master  bus
);

    localparam int            CW          = $clog2(BUF_DEPTH) + 1;
    localparam int            ZW          = $clog2(DONE_THRESH + 1);
    localparam logic [CW:0]   DEPTH_OCC   = (CW + 1)'(BUF_DEPTH);
    localparam logic [ZW-1:0] THRESH_C    = ZW'(DONE_THRESH);

    fetch_state_t  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic          inflight_q;
    logic [ZW-1:0] zero_cnt_q;
    logic [ZW-1:0] zero_cnt_d;

    logic [CW-1:0] count_w;
    fetch_pair_t   head_w;
    fetch_pair_t   push_data_w;
    logic [CW:0]   occ_w;
    logic          dec_valid_w;
    logic          deq_w;
    logic          redir_w;
    logic          issue_w;
    logic          resp_w;
    logic          resp_empty_w;
    logic          push_w;

    assign dec_valid_w  = (count_w != '0);
    assign deq_w        = dec_valid_w && bus.dec_ready;
    assign redir_w      = bus.redirect_valid && (state_q != DONE);
    // Occupancy after this cycle's dequeue, counting the outstanding response.
    assign occ_w        = {1'b0, count_w} - {{CW{1'b0}}, deq_w} + {{CW{1'b0}}, inflight_q};
    assign issue_w      = (state_q == RUN) && !bus.redirect_valid && (occ_w < DEPTH_OCC);
    assign resp_w       = inflight_q && !redir_w;
    assign resp_empty_w = resp_w && (bus.fetch_inst1 == '0);
    assign push_w       = resp_w && !resp_empty_w;
    assign push_data_w  = '{pc: req_pc_q, inst1: bus.fetch_inst1, inst2: bus.fetch_inst2};

    assign bus.fetch_pc  = fetch_pc_q;
    assign bus.fetch_req = issue_w;
    assign bus.dec_valid = dec_valid_w;
    assign bus.dec_pc    = dec_valid_w ? head_w.pc    : '0;
    assign bus.dec_inst1 = dec_valid_w ? head_w.inst1 : '0;
    assign bus.dec_inst2 = dec_valid_w ? head_w.inst2 : '0;
    assign bus.done      = (state_q == DONE);

    fetch_pair_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_w),
        .pop_i   (deq_w),
        .flush_i (redir_w),
        .data_i  (push_data_w),
        .count_o (count_w),
        .head_o  (head_w)
    );

    // Empty-response run length: cleared by real pairs and redirects, saturating.
    always_comb begin
        zero_cnt_d = zero_cnt_q;
        if (redir_w)
            zero_cnt_d = '0;
        else if (resp_empty_w)
            zero_cnt_d = (zero_cnt_q == THRESH_C) ? zero_cnt_q : zero_cnt_q + ZW'(1);
        else if (push_w)
            zero_cnt_d = '0;
    end

    // Sequencer FSM with PC register and in-flight tracking; redirect overrides state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            zero_cnt_q <= '0;
        end else begin
            inflight_q <= issue_w;
            zero_cnt_q <= zero_cnt_d;
            if (issue_w) fetch_pc_q <= fetch_pc_q + PC_STEP;
            if (redir_w) begin
                fetch_pc_q <= bus.redirect_pc;
                state_q    <= RUN;
            end else begin
                case (state_q)
                    IDLE:    state_q <= RUN;
                    RUN:     if (zero_cnt_q == THRESH_C) state_q <= DRAIN;
                    DRAIN:   if (count_w == '0 && !inflight_q) state_q <= DONE;
                    DONE:    state_q <= DONE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // PC of the outstanding request, tagged onto its response pair.
    always_ff @(posedge clk) begin
        if (issue_w) req_pc_q <= fetch_pc_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-cycle-latency fetch memory model.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Memory model: non-zero below mem_limit, zero beyond; answers one cycle after a request.
    logic [31:0] mem_limit;
    logic        rsp_req_q = 1'b0;
    logic [31:0] rsp_pc_q  = '0;
    always @(posedge clk) begin
        rsp_req_q <= bus.fetch_req;
        rsp_pc_q  <= bus.fetch_pc;
    end
    assign bus.fetch_inst1 = (rsp_req_q && rsp_pc_q < mem_limit) ? (32'hA000_0000 | rsp_pc_q) : 32'h0;
    assign bus.fetch_inst2 = (rsp_req_q && rsp_pc_q < mem_limit) ? (32'hB000_0000 | rsp_pc_q) : 32'h0;

    // Record every completed decode handshake.
    logic [31:0] got_pc[$];
    logic [31:0] got_i1[$];
    always @(posedge clk) begin
        if (!rst && bus.dec_valid && bus.dec_ready) begin
            got_pc.push_back(bus.dec_pc);
            got_i1.push_back(bus.dec_inst1);
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic ready);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready = ready;
        repeat (2) @(negedge clk);
        got_pc.delete();
        got_i1.delete();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        mem_limit = 32'h0000_1000;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_total++; if (bus.fetch_pc !== 32'h0) $display("FAIL rst_fetch_pc got %h want %h", bus.fetch_pc, 32'h0); else n_pass++;
        n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL rst_fetch_req got %b want 0", bus.fetch_req); else n_pass++;
        n_total++; if (bus.dec_valid !== 1'b0) $display("FAIL rst_dec_valid got %b want 0", bus.dec_valid); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.dec_pc !== 32'h0) $display("FAIL rst_dec_pc got %h want 0", bus.dec_pc); else n_pass++;
        got_pc.delete();
        got_i1.delete();
        rst = 1'b0;
        #1;
        n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL idle_no_req got %b want 0", bus.fetch_req); else n_pass++;
    endtask

    task automatic test_stream();
        nxt(); #1;
        n_total++; if (bus.fetch_req !== 1'b1) $display("FAIL first_req got %b want 1", bus.fetch_req); else n_pass++;
        n_total++; if (bus.fetch_pc !== 32'h0) $display("FAIL first_pc got %h want 0", bus.fetch_pc); else n_pass++;
        nxt(); #1;
        n_total++; if (bus.fetch_pc !== 32'h8) $display("FAIL second_pc got %h want 8", bus.fetch_pc); else n_pass++;
        n_total++; if (bus.dec_valid !== 1'b0) $display("FAIL no_bypass got %b want 0", bus.dec_valid); else n_pass++;
        nxt(); #1;
        n_total++; if (bus.dec_valid !== 1'b1) $display("FAIL pair0_valid got %b want 1", bus.dec_valid); else n_pass++;
        n_total++; if (bus.dec_pc !== 32'h0) $display("FAIL pair0_pc got %h want 0", bus.dec_pc); else n_pass++;
        n_total++; if (bus.dec_inst1 !== 32'hA000_0000) $display("FAIL pair0_inst1 got %h want a0000000", bus.dec_inst1); else n_pass++;
        nxt(); #1;
        n_total++; if (bus.dec_pc !== 32'h8 || bus.dec_valid !== 1'b1) $display("FAIL pair1_pc got %h/%b want 8/1", bus.dec_pc, bus.dec_valid); else n_pass++;
        nxt(); #1;
        n_total++; if (bus.dec_pc !== 32'h10) $display("FAIL pair2_pc got %h want 10", bus.dec_pc); else n_pass++;
        n_total++; if (bus.dec_inst2 !== 32'hB000_0010) $display("FAIL pair2_inst2 got %h want b0000010", bus.dec_inst2); else n_pass++;
    endtask

    task automatic test_backpressure();
        mem_limit = 32'h0000_1000;
        apply_reset(1'b0);
        for (int i = 1; i <= 6; i++) begin
            nxt(); #1;
            if (i == 3) begin
                n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL bp_issue_stop got %b want 0", bus.fetch_req); else n_pass++;
            end
        end
        n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL bp_hold_req got %b want 0", bus.fetch_req); else n_pass++;
        n_total++; if (bus.fetch_pc !== 32'h10) $display("FAIL bp_hold_fetch_pc got %h want 10", bus.fetch_pc); else n_pass++;
        n_total++; if (bus.dec_pc !== 32'h0 || bus.dec_valid !== 1'b1) $display("FAIL bp_hold_dec_pc got %h/%b want 0/1", bus.dec_pc, bus.dec_valid); else n_pass++;
        bus.dec_ready = 1'b1;
        repeat (6) nxt();
        #1;
        n_total++;
        if (got_pc.size() < 4 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h8 || got_pc[2] !== 32'h10 || got_pc[3] !== 32'h18)
            $display("FAIL bp_release_order got %p want 0,8,10,18 first", got_pc);
        else n_pass++;
        n_total++;
        if (got_i1.size() < 3 || got_i1[2] !== 32'hA000_0010)
            $display("FAIL bp_release_inst got %p want [2]=a0000010", got_i1);
        else n_pass++;
    endtask

    task automatic test_redirect();
        mem_limit = 32'h0000_1000;
        apply_reset(1'b1);
        repeat (3) nxt();
        #1;
        n_total++; if (bus.fetch_pc !== 32'h10 || bus.fetch_req !== 1'b1) $display("FAIL rd_req10 got %h/%b want 10/1", bus.fetch_pc, bus.fetch_req); else n_pass++;
        nxt();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h40;
        #1;
        n_total++; if (bus.fetch_req !== 1'b0) $display("FAIL rd_same_cycle_req got %b want 0", bus.fetch_req); else n_pass++;
        n_total++; if (bus.dec_pc !== 32'h8) $display("FAIL rd_head got %h want 8", bus.dec_pc); else n_pass++;
        nxt();
        bus.redirect_valid = 1'b0;
        #1;
        n_total++; if (bus.fetch_pc !== 32'h40 || bus.fetch_req !== 1'b1) $display("FAIL rd_next_req got %h/%b want 40/1", bus.fetch_pc, bus.fetch_req); else n_pass++;
        n_total++; if (bus.dec_valid !== 1'b0) $display("FAIL rd_flushed got %b want 0", bus.dec_valid); else n_pass++;
        repeat (2) nxt();
        #1;
        n_total++; if (bus.dec_pc !== 32'h40 || bus.dec_valid !== 1'b1) $display("FAIL rd_pair40 got %h/%b want 40/1", bus.dec_pc, bus.dec_valid); else n_pass++;
        nxt(); #1;
        n_total++; if (bus.dec_pc !== 32'h48) $display("FAIL rd_pair48 got %h want 48", bus.dec_pc); else n_pass++;
        nxt(); #1;
        n_total++;
        if (got_pc.size() < 4 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h8 || got_pc[2] !== 32'h40 || got_pc[3] !== 32'h48)
            $display("FAIL rd_sequence got %p want 0,8,40,48", got_pc);
        else n_pass++;
    endtask

    task automatic test_program_end();
        int req_off;
        int done_n;
        int done_drop;
        fetch_state_t st_at_stop;
        logic [31:0] pc_hold;
        req_off = 0;
        done_n = 0;
        done_drop = 0;
        st_at_stop = IDLE;
        mem_limit = 32'h20;
        apply_reset(1'b1);
        for (int n = 1; n <= 40; n++) begin
            nxt(); #1;
            if (req_off == 0 && bus.fetch_req === 1'b0) begin
                req_off = n;
                st_at_stop = dut.state_q;
            end
            if (done_n == 0 && bus.done === 1'b1) done_n = n;
            else if (done_n != 0 && bus.done !== 1'b1) done_drop++;
        end
        n_total++; if (req_off != 17) $display("FAIL end_req_stop_cycle got %0d want 17", req_off); else n_pass++;
        n_total++; if (st_at_stop !== DRAIN) $display("FAIL end_state_drain got %0d want %0d", st_at_stop, DRAIN); else n_pass++;
        n_total++; if (done_n != 19) $display("FAIL end_done_cycle got %0d want 19", done_n); else n_pass++;
        n_total++; if (done_drop != 0) $display("FAIL end_done_held got %0d drops want 0", done_drop); else n_pass++;
        n_total++;
        if (got_pc.size() != 4 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h8 || got_pc[2] !== 32'h10 || got_pc[3] !== 32'h18)
            $display("FAIL end_pairs got %p want 0,8,10,18", got_pc);
        else n_pass++;
        // A redirect while done must be ignored.
        pc_hold = bus.fetch_pc;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        nxt();
        bus.redirect_valid = 1'b0;
        #1;
        n_total++; if (bus.done !== 1'b1 || bus.fetch_req !== 1'b0) $display("FAIL done_redirect got done=%b req=%b want 1/0", bus.done, bus.fetch_req); else n_pass++;
        n_total++; if (bus.fetch_pc !== pc_hold) $display("FAIL done_redirect_pc got %h want %h", bus.fetch_pc, pc_hold); else n_pass++;
    endtask

    task automatic test_drain_redirect();
        mem_limit = 32'h20;
        apply_reset(1'b1);
        repeat (17) nxt();
        #1;
        n_total++; if (dut.state_q !== DRAIN) $display("FAIL dr_in_drain got %0d want %0d", dut.state_q, DRAIN); else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8;
        got_pc.delete();
        got_i1.delete();
        nxt();
        bus.redirect_valid = 1'b0;
        #1;
        n_total++; if (bus.fetch_pc !== 32'h8 || bus.fetch_req !== 1'b1) $display("FAIL dr_resume got %h/%b want 8/1", bus.fetch_pc, bus.fetch_req); else n_pass++;
        n_total++; if (dut.state_q !== RUN || dut.zero_cnt_q !== '0) $display("FAIL dr_state_zero got %0d/%0d want %0d/0", dut.state_q, dut.zero_cnt_q, RUN); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL dr_done got %b want 0", bus.done); else n_pass++;
        repeat (5) nxt();
        #1;
        n_total++;
        if (got_pc.size() < 3 || got_pc[0] !== 32'h8 || got_pc[1] !== 32'h10 || got_pc[2] !== 32'h18)
            $display("FAIL dr_pairs got %p want 8,10,18", got_pc);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        mem_limit = 32'h0000_1000;
        apply_reset(1'b0);
        repeat (3) nxt();
        #1;
        n_total++; if (bus.dec_valid !== 1'b1 || dut.inflight_q !== 1'b1) $display("FAIL mr_setup got %b/%b want 1/1", bus.dec_valid, dut.inflight_q); else n_pass++;
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h80;
        nxt(); #1;
        n_total++; if (bus.dec_valid !== 1'b0 || bus.done !== 1'b0) $display("FAIL mr_flush got %b/%b want 0/0", bus.dec_valid, bus.done); else n_pass++;
        n_total++; if (bus.fetch_pc !== 32'h0 || bus.fetch_req !== 1'b0) $display("FAIL mr_pc got %h/%b want 0/0", bus.fetch_pc, bus.fetch_req); else n_pass++;
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.dec_ready = 1'b1;
        nxt(); #1;
        n_total++; if (bus.fetch_req !== 1'b1 || bus.fetch_pc !== 32'h0) $display("FAIL mr_restart got %b/%h want 1/0", bus.fetch_req, bus.fetch_pc); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_program_end();
        test_drain_redirect();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- PC sequencer and buffering controller for the 2-wide instruction fetch stage.
- Drives the fetch PC, captures each {inst1, inst2} pair one cycle after its request, and queues pairs in a small buffer.
- Delivers pairs to decode over a valid/ready handshake.
- Handles branch redirects and end-of-program detection, asserting done after a run of empty fetches.

Parameters:
RESET_PC, 32'd0, fetch address after reset
PC_STEP, 32'd8, PC increment per issued request (two 32-bit instructions)
BUF_DEPTH, 2, fetch-pair buffer entries (power of 2, >=2)
DONE_THRESH, 10, consecutive empty responses that end fetching

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_pc  out  32  address presented to the fetch unit (sampled at posedge)
fetch_req  out  1  current fetch_pc is a live request this cycle
fetch_inst1  in  32  fetch-unit inst1, valid the cycle after a request
fetch_inst2  in  32  fetch-unit inst2, valid the cycle after a request
dec_valid  out  1  buffer head valid
dec_ready  in  1  decode accepts head
dec_pc  out  32  PC of head pair
dec_inst1  out  32  head inst1
dec_inst2  out  32  head inst2
redirect_valid  in  1  branch/flush redirect
redirect_pc  in  32  redirect target (4-byte aligned)
done  out  1  fetching finished and buffer drained

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC, fetch_req = 0, dec_valid = 0, done = 0.
  - Buffer empty, in-flight flag clear, zero_cnt = 0, state = IDLE.
  - dec_pc/inst fields = 0.
- States:
  - IDLE -> RUN after one cycle.
  - RUN -> DRAIN when zero_cnt reaches DONE_THRESH.
  - DRAIN -> DONE when buffer is empty and nothing is in flight.
  - DONE is terminal until rst.
- Dequeue: deq = dec_valid & dec_ready.
- Issue, combinational:
  - fetch_req = (state==RUN) & ~redirect_valid & (count - deq + inflight < BUF_DEPTH).
  - No request in IDLE, DRAIN or DONE.
- Issue, registered: on an issue cycle, inflight <= 1, req_pc_q <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP (mod 2^32, wraps silently). Otherwise inflight <= 0 and fetch_pc holds.
- Response: the cycle with inflight = 1 is the response cycle; sample fetch_inst1/2 in that cycle.
  - Empty response = fetch_inst1 == 0. It is dropped (not enqueued) and increments zero_cnt, saturating at DONE_THRESH.
  - Non-empty response enqueues {req_pc_q, inst1, inst2} and clears zero_cnt.
  - Issue rule guarantees space; an enqueue into a full buffer is an assertion failure.
- Simultaneous enqueue and dequeue: both happen, count unchanged. When the buffer is empty, an enqueue appears at dec_valid the next cycle, with no bypass.
- dec_* fields are stable while dec_valid & ~dec_ready.
- Redirect (any state except DONE):
  - Same cycle: no issue. An in-flight response arriving this cycle is discarded.
  - Next cycle: buffer flushed (count = 0, dec_valid = 0), inflight = 0, zero_cnt = 0, fetch_pc = redirect_pc, state = RUN. This applies from DRAIN as well.
  - First request to redirect_pc is the cycle after redirect.
  - Redirect in DONE is ignored.
- Redirect has priority over a same-cycle dequeue: the dequeue completes from decode's view, and the flush still empties the buffer.
- done = (state==DONE), registered, held until rst.
- rst mid-operation overrides redirect and all traffic. The next cycle equals the post-reset state.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_pair_t {pc[31:0], inst1[31:0], inst2[31:0]}.
  - fetch_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - Constants PC_STEP_DEFAULT, DONE_THRESH_DEFAULT.
- One sub-module: fetch_pair_fifo.
  - Synchronous FIFO of fetch_pair_t, depth BUF_DEPTH.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push.
- fetch_ctrl holds the FSM, PC register, inflight tracking and zero counter.

Test Plan:
- Reset then run, dec_ready = 1, memory non-zero:
  - fetch_req first high in cycle 2 at pc 0.
  - Pairs emerge with dec_pc 0, 8, 16…, one per cycle after fill.
- Backpressure, dec_ready = 0 for 6 cycles:
  - Issue stops once count + inflight == 2.
  - dec_pc holds at 0; fetch_pc holds at 16.
  - On release, pairs 0, 8, 16 arrive in order with no loss or duplicate.
- Redirect to 0x40 while a request to 0x10 is in flight:
  - The 0x10 response is discarded; buffer flushes.
  - Next request is fetch_pc 0x40; dec_pc sequence resumes 0x40, 0x48.
- Program ends at 0x20, memory zero beyond:
  - After 10 empty responses, state DRAIN and fetch_req = 0.
  - Once decode drains pairs 0x0–0x18, done = 1 and stays 1.
- Redirect to 0x8 during DRAIN:
  - done stays 0, state RUN, zero_cnt cleared.
  - Fetch resumes at 0x8.
- rst asserted mid-stream with buffer full and inflight:
  - Next cycle dec_valid = 0, done = 0, fetch_pc = RESET_PC.
  - A redirect in the same cycle is ignored.
